pipe_ctrl: RTL and testbench

- Parametrised pipeline-register and hazard controller for the pipelined RV32I core. It replaces the fixed, always-enabled pipeline register bank.
- Holds NSTAGES stage boundaries (stage 0 = IF/ID, stage 1 = ID/EX, stages 2..NSTAGES-1 downstream: EX/MEM, MEM/WB, ...). Each stage carries a valid bit, payload and register metadata.
- Detects load-use hazards (stall plus bubble), applies branch/jump redirect flushes, produces EX operand forwarding selects, and keeps saturating stall/flush counters.

---
 rtl/pipe_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Purpose  : Pipeline-register bank and hazard controller for the pipelined
//             RV32I core. Holds NSTAGES stage boundaries (0 = IF/ID,
//             1 = ID/EX, 2.. = EX/MEM, MEM/WB, ...). It also handles
//             load-use stalls with bubble insertion and redirect flushes,
//             generates the EX operand forwarding selects, and keeps
//             saturating stall/flush counters.
//  Ports    :
//    clk            - clock, rising-edge
//    rst            - asynchronous active-low reset
//    in_valid       - fetch slot valid
//    in_data        - fetch payload loaded into stage 0
//    stage_in       - payload for stage k from slice k (k >= 1); slice 0 unused
//    dec_rs1/rs2/rd - register fields of the instruction in stage 0
//    dec_regwrite   - stage-0 instruction writes rd
//    dec_is_load    - stage-0 instruction is a load
//    redirect       - taken branch/jump resolved from stage 1
//    pc_en          - fetch PC may advance
//    stall          - load-use stall this cycle
//    stage_valid    - valid bit per stage
//    stage_data     - registered payload per stage
//    stage_rd       - rd per stage (stage 0 = dec_rd)
//    stage_regwrite - regwrite per stage, gated by valid
//    fwd_a/fwd_b    - stage-1 operand select: 00 RF, 01 stage 2, 10 stage 3
//    stall_cnt      - saturating load-use stall counter
//    flush_cnt      - saturating redirect flush counter
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int W       = 96,
    parameter int NSTAGES = 4,   // legal range 4..8
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [W-1:0]         in_data,
    input  logic [NSTAGES*W-1:0] stage_in,
    input  logic [4:0]           dec_rs1,
    input  logic [4:0]           dec_rs2,
    input  logic [4:0]           dec_rd,
    input  logic                 dec_regwrite,
    input  logic                 dec_is_load,
    input  logic                 redirect,
    output logic                 pc_en,
    output logic                 stall,
    output logic [NSTAGES-1:0]   stage_valid,
    output logic [NSTAGES*W-1:0] stage_data,
    output logic [NSTAGES*5-1:0] stage_rd,
    output logic [NSTAGES-1:0]   stage_regwrite,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    // Stage 0 carries only valid + payload; its register fields come live
    // from the decoder, so metadata arrays start at stage 1.
    logic [NSTAGES-1:0] r_valid;
    logic [W-1:0]       r_data [NSTAGES];
    logic [4:0]         r_rd   [1:NSTAGES-1];
    logic [NSTAGES-1:1] r_regwrite;
    logic [NSTAGES-1:1] r_is_load;
    logic [4:0]         r_rs1;
    logic [4:0]         r_rs2;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    logic w_stall;
    logic w_s1_hit;
    logic w_s2_wr;
    logic w_s3_wr;
    logic w_unused_bits;

    // ------------------------------------------------------------------
    // Load-use hazard: a valid load in stage 1 whose rd feeds stage 0.
    // A redirect kills stage 0 anyway, so it suppresses the stall.
    // ------------------------------------------------------------------
    assign w_s1_hit = (r_rd[1] == dec_rs1) | (r_rd[1] == dec_rs2);
    assign w_stall  = r_valid[1] & r_is_load[1] & (r_rd[1] != 5'd0) &
                      r_valid[0] & w_s1_hit & ~redirect;

    assign stall = w_stall;
    assign pc_en = ~w_stall;

    // ------------------------------------------------------------------
    // Stage registers and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid     <= '0;
            r_regwrite  <= '0;
            r_is_load   <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            for (int k = 0; k < NSTAGES; k++) begin
                r_data[k] <= '0;
            end
            for (int k = 1; k < NSTAGES; k++) begin
                r_rd[k] <= '0;
            end
        end else begin
            // Downstream stages advance every cycle regardless of
            // stalls or flushes at the front.
            for (int k = 2; k < NSTAGES; k++) begin
                r_valid[k]    <= r_valid[k-1];
                r_data[k]     <= stage_in[k*W +: W];
                r_rd[k]       <= r_rd[k-1];
                r_regwrite[k] <= r_regwrite[k-1];
                r_is_load[k]  <= r_is_load[k-1];
            end

            if (redirect || w_stall) begin
                // Stage 0 is squashed on redirect, held on stall.
                if (redirect) begin
                    r_valid[0] <= 1'b0;
                    r_data[0]  <= '0;
                end
                // Stage 1 becomes an empty bubble. Its register fields are
                // cleared too so the bubble can never match for forwarding.
                r_valid[1]    <= 1'b0;
                r_data[1]     <= '0;
                r_rd[1]       <= '0;
                r_rs1         <= '0;
                r_rs2         <= '0;
                r_regwrite[1] <= 1'b0;
                r_is_load[1]  <= 1'b0;
            end else begin
                r_valid[0]    <= in_valid;
                r_data[0]     <= in_data;
                r_valid[1]    <= r_valid[0];
                r_data[1]     <= stage_in[W +: W];
                r_rd[1]       <= dec_rd;
                r_rs1         <= dec_rs1;
                r_rs2         <= dec_rs2;
                r_regwrite[1] <= dec_regwrite;
                r_is_load[1]  <= dec_is_load;
            end

            // w_stall already excludes redirect, so a combined cycle
            // counts only as a flush.
            if (redirect && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + c_cnt_one;
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
        end
    end

    // ------------------------------------------------------------------
    // Forwarding to stage 1 operands; stage 2 (youngest) takes priority.
    // ------------------------------------------------------------------
    assign w_s2_wr = r_valid[2] & r_regwrite[2] & (r_rd[2] != 5'd0);
    assign w_s3_wr = r_valid[3] & r_regwrite[3] & (r_rd[3] != 5'd0);

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (w_s2_wr && (r_rd[2] == r_rs1)) begin
            fwd_a = 2'b01;
        end else if (w_s3_wr && (r_rd[3] == r_rs1)) begin
            fwd_a = 2'b10;
        end
        if (w_s2_wr && (r_rd[2] == r_rs2)) begin
            fwd_b = 2'b01;
        end else if (w_s3_wr && (r_rd[3] == r_rs2)) begin
            fwd_b = 2'b10;
        end
    end

    // ------------------------------------------------------------------
    // Output packing
    // ------------------------------------------------------------------
    assign stage_valid = r_valid;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

    for (genvar k = 0; k < NSTAGES; k++) begin : g_out
        assign stage_data[k*W +: W] = r_data[k];
        if (k == 0) begin : g_s0
            assign stage_rd[4:0]     = dec_rd;
            assign stage_regwrite[0] = dec_regwrite & r_valid[0];
        end else begin : g_sk
            assign stage_rd[k*5 +: 5] = r_rd[k];
            assign stage_regwrite[k]  = r_regwrite[k] & r_valid[k];
        end
    end

    // Slice 0 of stage_in has no destination, and the last stage's is_load
    // has no consumer downstream.
    assign w_unused_bits = ^{stage_in[W-1:0], r_is_load[NSTAGES-1]};

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
module tb_pipe_ctrl;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int N6 = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;

    // ---------------- main instance (NSTAGES=4, CNT_W=16) ----------------
    logic           rst = 1'b1;
    logic           in_valid;
    logic [W-1:0]   in_data;
    logic [N*W-1:0] stage_in;
    logic [4:0]     dec_rs1, dec_rs2, dec_rd;
    logic           dec_regwrite, dec_is_load, redirect;
    logic           pc_en, stall;
    logic [N-1:0]   stage_valid;
    logic [N*W-1:0] stage_data;
    logic [N*5-1:0] stage_rd;
    logic [N-1:0]   stage_regwrite;
    logic [1:0]     fwd_a, fwd_b;
    logic [15:0]    stall_cnt, flush_cnt;

    pipe_ctrl #(.W(W), .NSTAGES(N), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .stage_in(stage_in), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rd(dec_rd), .dec_regwrite(dec_regwrite), .dec_is_load(dec_is_load),
        .redirect(redirect), .pc_en(pc_en), .stall(stall),
        .stage_valid(stage_valid), .stage_data(stage_data), .stage_rd(stage_rd),
        .stage_regwrite(stage_regwrite), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // ---------------- second instance (NSTAGES=6, CNT_W=2) ----------------
    logic            x_rst = 1'b1;
    logic            x_in_valid;
    logic [W-1:0]    x_in_data;
    logic [N6*W-1:0] x_stage_in;
    logic            x_redirect;
    logic            x_pc_en, x_stall;
    logic [N6-1:0]   x_stage_valid;
    logic [N6*W-1:0] x_stage_data;
    logic [N6*5-1:0] x_stage_rd;
    logic [N6-1:0]   x_stage_regwrite;
    logic [1:0]      x_fwd_a, x_fwd_b;
    logic [1:0]      x_stall_cnt, x_flush_cnt;

    pipe_ctrl #(.W(W), .NSTAGES(N6), .CNT_W(2)) u_six (
        .clk(clk), .rst(x_rst), .in_valid(x_in_valid), .in_data(x_in_data),
        .stage_in(x_stage_in), .dec_rs1(5'd0), .dec_rs2(5'd0),
        .dec_rd(5'd0), .dec_regwrite(1'b0), .dec_is_load(1'b0),
        .redirect(x_redirect), .pc_en(x_pc_en), .stall(x_stall),
        .stage_valid(x_stage_valid), .stage_data(x_stage_data),
        .stage_rd(x_stage_rd), .stage_regwrite(x_stage_regwrite),
        .fwd_a(x_fwd_a), .fwd_b(x_fwd_b),
        .stall_cnt(x_stall_cnt), .flush_cnt(x_flush_cnt)
    );

    // Top-level behaviour: each stage passes its payload on unchanged.
    always_comb begin
        x_stage_in = '0;
        x_stage_in[W-1:0] = 16'hDEAD;
        for (int k = 1; k < N6; k++) begin
            x_stage_in[k*W +: W] = x_stage_data[(k-1)*W +: W];
        end
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 1'b0; in_data = '0;
        dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
        dec_regwrite = 1'b0; dec_is_load = 1'b0; redirect = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic x_do_reset();
        x_rst = 1'b0;
        x_in_valid = 1'b0; x_in_data = '0; x_redirect = 1'b0;
        @(posedge clk);
        #1;
        x_rst = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_total++; if (stage_valid !== 4'b0000) $display("FAIL rst_valid: got %b want 0000", stage_valid); else n_pass++;
        n_total++; if (pc_en !== 1'b1) $display("FAIL rst_pc_en: got %b want 1", pc_en); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else n_pass++;
        n_total++; if ({fwd_a, fwd_b} !== 4'b0000) $display("FAIL rst_fwd: got %b want 0000", {fwd_a, fwd_b}); else n_pass++;
        n_total++; if (stall_cnt !== 16'd0) $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt); else n_pass++;
        n_total++; if (flush_cnt !== 16'd0) $display("FAIL rst_flush_cnt: got %0d want 0", flush_cnt); else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        in_valid = 1'b1; in_data = 16'h1111; tick();
        // s0 = lw x5
        dec_rd = 5'd5; dec_is_load = 1'b1; dec_regwrite = 1'b1; in_data = 16'h2222; tick();
        // s0 uses x5 while the load sits in stage 1
        dec_rd = 5'd6; dec_is_load = 1'b0; dec_rs1 = 5'd5; in_data = 16'h3333; #1;
        n_total++; if (stall !== 1'b1) $display("FAIL lu_stall: got %b want 1", stall); else n_pass++;
        n_total++; if (pc_en !== 1'b0) $display("FAIL lu_pc_en: got %b want 0", pc_en); else n_pass++;
        tick();
        n_total++; if (stall !== 1'b0) $display("FAIL lu_stall_once: got %b want 0", stall); else n_pass++;
        n_total++; if (pc_en !== 1'b1) $display("FAIL lu_pc_en_after: got %b want 1", pc_en); else n_pass++;
        n_total++; if (stage_valid !== 4'b0101) $display("FAIL lu_valid: got %b want 0101", stage_valid); else n_pass++;
        n_total++; if (stage_data[W +: W] !== 16'h0000) $display("FAIL lu_bubble_data: got %h want 0000", stage_data[W +: W]); else n_pass++;
        n_total++; if (stage_data[W-1:0] !== 16'h2222) $display("FAIL lu_s0_hold: got %h want 2222", stage_data[W-1:0]); else n_pass++;
        n_total++; if (stall_cnt !== 16'd1) $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); else n_pass++;
        n_total++; if (fwd_a !== 2'b00) $display("FAIL lu_fwd_bubble: got %b want 00", fwd_a); else n_pass++;
        tick();
        n_total++; if (fwd_a !== 2'b10) $display("FAIL lu_fwd_a_s3: got %b want 10", fwd_a); else n_pass++;
        n_total++; if (stage_data[W-1:0] !== 16'h3333) $display("FAIL lu_s0_next: got %h want 3333", stage_data[W-1:0]); else n_pass++;
        n_total++; if (stall_cnt !== 16'd1) $display("FAIL lu_stall_cnt_hold: got %0d want 1", stall_cnt); else n_pass++;
    endtask

    // Builds s3 = X(rd=rdv,rw=1), s2 = Y(rd=rdv,rw=y_rw), s1 = Z(rs2=rdv),
    // s0 valid with dec_rd=9.
    task automatic fwd_setup(input logic y_rw, input logic [4:0] rdv);
        do_reset();
        in_valid = 1'b1; tick();
        dec_rd = rdv; dec_regwrite = 1'b1; tick();
        dec_rd = rdv; dec_regwrite = y_rw; tick();
        dec_rd = 5'd1; dec_regwrite = 1'b1; dec_rs2 = rdv; tick();
        dec_rd = 5'd9; dec_regwrite = 1'b1; dec_rs2 = 5'd0; #1;
    endtask

    task automatic test_forwarding();
        fwd_setup(1'b1, 5'd7);
        n_total++; if (fwd_b !== 2'b01) $display("FAIL fwd_b_s2_wins: got %b want 01", fwd_b); else n_pass++;
        n_total++; if (fwd_a !== 2'b00) $display("FAIL fwd_a_none: got %b want 00", fwd_a); else n_pass++;
        n_total++; if (stage_rd !== {5'd7, 5'd7, 5'd1, 5'd9}) $display("FAIL fwd_stage_rd: got %h want %h", stage_rd, {5'd7, 5'd7, 5'd1, 5'd9}); else n_pass++;
        n_total++; if (stage_regwrite !== 4'b1111) $display("FAIL fwd_regwrite_all: got %b want 1111", stage_regwrite); else n_pass++;
        fwd_setup(1'b0, 5'd7);
        n_total++; if (fwd_b !== 2'b10) $display("FAIL fwd_b_s3: got %b want 10", fwd_b); else n_pass++;
        n_total++; if (stage_regwrite !== 4'b1011) $display("FAIL fwd_regwrite_s2off: got %b want 1011", stage_regwrite); else n_pass++;
        fwd_setup(1'b1, 5'd0);
        n_total++; if (fwd_b !== 2'b00) $display("FAIL fwd_b_x0: got %b want 00", fwd_b); else n_pass++;
    endtask

    task automatic test_redirect_hazard();
        do_reset();
        in_valid = 1'b1; in_data = 16'h1111; tick();
        dec_rd = 5'd5; dec_is_load = 1'b1; dec_regwrite = 1'b1; in_data = 16'h2222; tick();
        dec_rd = 5'd6; dec_is_load = 1'b0; dec_rs1 = 5'd5; in_data = 16'h3333;
        redirect = 1'b1; #1;
        n_total++; if (stall !== 1'b0) $display("FAIL rh_stall: got %b want 0", stall); else n_pass++;
        n_total++; if (pc_en !== 1'b1) $display("FAIL rh_pc_en: got %b want 1", pc_en); else n_pass++;
        tick();
        redirect = 1'b0; #1;
        n_total++; if (stage_valid !== 4'b0100) $display("FAIL rh_valid: got %b want 0100", stage_valid); else n_pass++;
        n_total++; if (stage_data[2*W-1:0] !== 32'h0) $display("FAIL rh_data: got %h want 00000000", stage_data[2*W-1:0]); else n_pass++;
        n_total++; if (flush_cnt !== 16'd1) $display("FAIL rh_flush_cnt: got %0d want 1", flush_cnt); else n_pass++;
        n_total++; if (stall_cnt !== 16'd0) $display("FAIL rh_stall_cnt: got %0d want 0", stall_cnt); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        redirect = 1'b1; tick();
        redirect = 1'b0; in_valid = 1'b1; in_data = 16'h5555;
        dec_rd = 5'd3; dec_regwrite = 1'b1;
        repeat (4) tick();
        n_total++; if (stage_valid !== 4'b1111) $display("FAIL mr_filled: got %b want 1111", stage_valid); else n_pass++;
        n_total++; if (flush_cnt !== 16'd1) $display("FAIL mr_flush_pre: got %0d want 1", flush_cnt); else n_pass++;
        #2;
        rst = 1'b0; #1;
        n_total++; if (stage_valid !== 4'b0000) $display("FAIL mr_valid: got %b want 0000", stage_valid); else n_pass++;
        n_total++; if (flush_cnt !== 16'd0) $display("FAIL mr_flush_cnt: got %0d want 0", flush_cnt); else n_pass++;
        n_total++; if (pc_en !== 1'b1) $display("FAIL mr_pc_en: got %b want 1", pc_en); else n_pass++;
        n_total++; if (stage_regwrite !== 4'b0000) $display("FAIL mr_regwrite: got %b want 0000", stage_regwrite); else n_pass++;
        n_total++; if (stage_data !== '0) $display("FAIL mr_data: got %h want 0", stage_data); else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_counter_sat();
        logic [1:0] exp_cnt;
        x_do_reset();
        x_redirect = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            exp_cnt = (i < 3) ? 2'(i) : 2'd3;
            n_total++; if (x_flush_cnt !== exp_cnt) $display("FAIL sat_flush_%0d: got %0d want %0d", i, x_flush_cnt, exp_cnt); else n_pass++;
        end
        x_redirect = 1'b0; tick();
        n_total++; if (x_flush_cnt !== 2'd3) $display("FAIL sat_hold: got %0d want 3", x_flush_cnt); else n_pass++;
        n_total++; if (x_stall_cnt !== 2'd0) $display("FAIL sat_stall_cnt: got %0d want 0", x_stall_cnt); else n_pass++;
    endtask

    task automatic test_stream6();
        int  k;
        logic exp_v;
        x_do_reset();
        for (int c = 0; c <= 16; c++) begin
            x_in_valid = (c < 10);
            x_in_data  = 16'hC000 + 16'(c);
            tick();
            k = c - 5;
            exp_v = (k >= 0) && (k < 10);
            n_total++; if (x_stage_valid[5] !== exp_v) $display("FAIL s6_valid_c%0d: got %b want %b", c, x_stage_valid[5], exp_v); else n_pass++;
            if (exp_v) begin
                n_total++; if (x_stage_data[5*W +: W] !== 16'hC000 + 16'(k)) $display("FAIL s6_data_c%0d: got %h want %h", c, x_stage_data[5*W +: W], 16'hC000 + 16'(k)); else n_pass++;
            end
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        clear_inputs();
        stage_in = {16'hA303, 16'hA202, 16'hBEEF, 16'hA000};
        x_in_valid = 1'b0; x_in_data = '0; x_redirect = 1'b0;
        #1;
        rst = 1'b0; x_rst = 1'b0;
        #1;
        test_reset();
        test_load_use();
        test_forwarding();
        test_redirect_hazard();
        test_reset_midstream();
        test_counter_sat();
        test_stream6();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
